// File: rtl/mux_arb_n_pkg.sv
// mux_arb_n_pkg: arbitration mode encodings and channel-index width helper for mux_arb_n.
package mux_arb_n_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// rr_arbiter: combinational one-hot grant, either fixed priority or round-robin from ptr.
module rr_arbiter
    import mux_arb_n_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = ARB_RR,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    int base;
    logic [CH_W-1:0] order [NUM_CH];

    assign base = (RR_MODE == ARB_RR) ? int'(ptr) : 0;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_order
        assign order[k] = CH_W'((base + k) % NUM_CH);
    end

    // Scan from the farthest candidate back so the nearest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[order[k]]) begin
                grant            = '0;
                grant[order[k]]  = 1'b1;
                grant_idx        = order[k];
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel valid/ready arbitration mux with a registered output stage.
// Optional MUX_ARB_N_FORCE_SEL_EN adds force_en/force_ch to override the arbiter.
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = ARB_RR,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
`ifdef MUX_ARB_N_FORCE_SEL_EN
    input  logic                    force_en,
    input  logic [CH_W-1:0]         force_ch,
`endif
    input  logic                    out_ready
);

    logic [CH_W-1:0]   rr_ptr;
    logic [NUM_CH-1:0] arb_grant;
    logic [CH_W-1:0]   arb_idx;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              forced;
    logic              load;
    logic              fire;

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

`ifdef MUX_ARB_N_FORCE_SEL_EN
    logic [NUM_CH-1:0] force_grant;
    assign forced = force_en;
    always_comb begin
        force_grant = '0;
        if (int'(force_ch) < NUM_CH && in_valid[force_ch])
            force_grant[force_ch] = 1'b1;
    end
    assign grant     = forced ? force_grant : arb_grant;
    assign grant_idx = forced ? force_ch : arb_idx;
`else
    assign forced    = 1'b0;
    assign grant     = arb_grant;
    assign grant_idx = arb_idx;
`endif

    assign load     = !out_valid || out_ready;
    assign in_ready = (rst_n && load) ? grant : '0;
    assign fire     = |in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
            out_ch    <= grant_idx;
            if (RR_MODE == ARB_RR && !forced)
                rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: directed checks of mux_arb_n in round-robin and fixed-priority builds.
module tb_mux_arb_n;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic         out_ready;
    logic [3:0]   rr_in_ready, fp_in_ready;
    logic         rr_out_valid, fp_out_valid;
    logic [31:0]  rr_out_data, fp_out_data;
    logic [1:0]   rr_out_ch, fp_out_ch;
`ifdef MUX_ARB_N_FORCE_SEL_EN
    logic         force_en = 1'b0;
    logic [1:0]   force_ch = 2'd0;
`endif
    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux_arb_n #(.WIDTH(32), .NUM_CH(4), .RR_MODE(1)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rr_in_ready),
        .out_valid (rr_out_valid),
        .out_data  (rr_out_data),
        .out_ch    (rr_out_ch),
`ifdef MUX_ARB_N_FORCE_SEL_EN
        .force_en  (force_en),
        .force_ch  (force_ch),
`endif
        .out_ready (out_ready)
    );

    mux_arb_n #(.WIDTH(32), .NUM_CH(4), .RR_MODE(0)) u_fp (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (fp_in_ready),
        .out_valid (fp_out_valid),
        .out_data  (fp_out_data),
        .out_ch    (fp_out_ch),
`ifdef MUX_ARB_N_FORCE_SEL_EN
        .force_en  (1'b0),
        .force_ch  (2'd0),
`endif
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int ch);
        return (ch == 2) ? 32'hDEADBEEF : 32'hA000_0000 + 32'(ch);
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = {word(3), word(2), word(1), word(0)};
        tick();
        tick();
        chk("rst_out_valid", 64'(rr_out_valid), 64'd0);
        chk("rst_out_data", 64'(rr_out_data), 64'd0);
        chk("rst_out_ch", 64'(rr_out_ch), 64'd0);
        chk("rst_in_ready", 64'(rr_in_ready), 64'd0);

        rst_n    = 1'b1;
        in_valid = 4'b0100;
        #1;
        chk("single_in_ready", 64'(rr_in_ready), 64'h4);
        tick();
        chk("single_out_valid", 64'(rr_out_valid), 64'd1);
        chk("single_out_data", 64'(rr_out_data), 64'hDEADBEEF);
        chk("single_out_ch", 64'(rr_out_ch), 64'd2);

        in_valid = 4'b0000;
        tick();
        chk("pop_out_valid", 64'(rr_out_valid), 64'd0);
        chk("pop_out_data_held", 64'(rr_out_data), 64'hDEADBEEF);

        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_out_ch", 64'(rr_out_ch), 64'(i % 4));
            chk("rr_out_data", 64'(rr_out_data), 64'(word(i % 4)));
        end

        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", 64'(rr_in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_out_valid", 64'(rr_out_valid), 64'd1);
            chk("stall_out_ch", 64'(rr_out_ch), 64'd0);
            chk("stall_out_data", 64'(rr_out_data), 64'(word(0)));
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(rr_in_ready), 64'h2);
        tick();
        chk("release_out_ch", 64'(rr_out_ch), 64'd1);

        out_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_out_valid", 64'(rr_out_valid), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("midrst_ptr_in_ready", 64'(rr_in_ready), 64'h1);
        tick();
        chk("midrst_out_ch", 64'(rr_out_ch), 64'd0);

        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fp_in_ready", 64'(fp_in_ready), 64'h2);
            tick();
            chk("fp_out_valid", 64'(fp_out_valid), 64'd1);
            chk("fp_out_ch", 64'(fp_out_ch), 64'd1);
        end

`ifdef MUX_ARB_N_FORCE_SEL_EN
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        force_en = 1'b1;
        force_ch = 2'd3;
        in_valid = 4'b1001;
        #1;
        chk("force_in_ready", 64'(rr_in_ready), 64'h8);
        tick();
        chk("force_out_ch", 64'(rr_out_ch), 64'd3);
        force_en = 1'b0;
        in_valid = 4'b1111;
        #1;
        chk("force_ptr_kept", 64'(rr_in_ready), 64'h1);
        force_en = 1'b1;
        in_valid = 4'b0001;
        #1;
        chk("force_no_grant", 64'(rr_in_ready), 64'd0);
        force_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
